// File: rtl/param_exec_unit.sv
// rtl/param_exec_unit.sv - four-state fetch/execute/writeback unit over a small register file
module param_exec_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] imm,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [NREGS];
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] rs1_q, rs2_q, rd_q;
  logic [DATA_W-1:0] imm_q, a_q, b_q, res_q;
  logic [3:0]        flg_q;
  logic              wr_q, ill_q;

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] alu_res;
  logic [3:0]        alu_flg;
  logic              alu_wr, alu_ill;

  assign busy     = (state != IDLE);
  assign dbg_data = regs[dbg_addr];

  // flags bits: {CV, SO, GT, Z}; untouched bits keep their current value
  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_flg = flags;
    alu_wr  = 1'b1;
    alu_ill = 1'b0;
    case (op_q)
      4'd0:  alu_res = a_q;
      4'd1:  alu_res = imm_q;
      4'd2:  begin sum = {1'b0, a_q} + {1'b0, b_q}; alu_res = sum[DATA_W-1:0]; alu_flg[3] = sum[DATA_W]; end
      4'd3:  begin sum = {1'b0, a_q} - {1'b0, b_q}; alu_res = sum[DATA_W-1:0]; alu_flg[3] = sum[DATA_W]; end
      4'd4:  alu_res = a_q & b_q;
      4'd5:  alu_res = a_q | b_q;
      4'd6:  alu_res = a_q ^ b_q;
      4'd7:  begin alu_res = {a_q[DATA_W-2:0], 1'b0}; alu_flg[2] = a_q[DATA_W-1]; end
      4'd8:  begin alu_res = {1'b0, a_q[DATA_W-1:1]}; alu_flg[2] = a_q[0]; end
      4'd9:  begin
        sum        = {1'b0, b_q} - {1'b0, a_q};
        alu_res    = sum[DATA_W-1:0];
        alu_flg[1] = (a_q > b_q);
        alu_wr     = 1'b0;
      end
      4'd10: begin sum = {1'b0, a_q} + ONE; alu_res = sum[DATA_W-1:0]; alu_flg[3] = sum[DATA_W]; end
      4'd11: begin sum = {1'b0, a_q} - ONE; alu_res = sum[DATA_W-1:0]; alu_flg[3] = sum[DATA_W]; end
      4'd12: begin
        sum        = {1'b0, a_q} + {1'b0, b_q} + {{DATA_W{1'b0}}, flags[3]};
        alu_res    = sum[DATA_W-1:0];
        alu_flg[3] = sum[DATA_W];
      end
      default: begin
        alu_res = result;
        alu_wr  = 1'b0;
        alu_ill = 1'b1;
      end
    endcase
    if (!alu_ill) alu_flg[0] = (alu_res == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      op_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      imm_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      flg_q  <= '0;
      wr_q   <= 1'b0;
      ill_q  <= 1'b0;
      result <= '0;
      flags  <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_q  <= op;
          rs1_q <= rs1;
          rs2_q <= rs2;
          rd_q  <= rd;
          imm_q <= imm;
          state <= FETCH;
        end
        FETCH: begin
          a_q   <= regs[rs1_q];
          b_q   <= regs[rs2_q];
          state <= EXEC;
        end
        EXEC: begin
          res_q <= alu_res;
          flg_q <= alu_flg;
          wr_q  <= alu_wr;
          ill_q <= alu_ill;
          state <= WB;
        end
        WB: begin
          if (!ill_q) begin
            result <= res_q;
            flags  <= flg_q;
          end
          if (wr_q) regs[rd_q] <= res_q;
          done  <= 1'b1;
          err   <= ill_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_exec_unit.sv
// tb/tb_param_exec_unit.sv - scoreboard bench for param_exec_unit at 8/3 and 16/4 widths
module tb_param_exec_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        start_a, start_b;
  logic [3:0]  op_a, op_b;
  logic [2:0]  rs1_a, rs2_a, rd_a, dbg_addr_a;
  logic [3:0]  rs1_b, rs2_b, rd_b, dbg_addr_b;
  logic [7:0]  imm_a, result_a, dbg_data_a;
  logic [15:0] imm_b, result_b, dbg_data_b;
  logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [3:0]  flags_a, flags_b;

  param_exec_unit #(.DATA_W(8), .ADDR_W(3)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .op(op_a),
    .rs1(rs1_a), .rs2(rs2_a), .rd(rd_a), .imm(imm_a),
    .busy(busy_a), .done(done_a), .err(err_a), .result(result_a), .flags(flags_a),
    .dbg_addr(dbg_addr_a), .dbg_data(dbg_data_a)
  );

  param_exec_unit #(.DATA_W(16), .ADDR_W(4)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .op(op_b),
    .rs1(rs1_b), .rs2(rs2_b), .rd(rd_b), .imm(imm_b),
    .busy(busy_b), .done(done_b), .err(err_b), .result(result_b), .flags(flags_b),
    .dbg_addr(dbg_addr_b), .dbg_data(dbg_data_b)
  );

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
    logic        err;
    int          done_cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    exp_t ea;
    exp_t eb;
    if (done_a) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL done_a: unexpected done at cycle %0d", cyc);
      end else begin
        ea = q_a.pop_front();
        chk("result_a", 32'(result_a), 32'(ea.res));
        chk("flags_a", 32'(flags_a), 32'(ea.flg));
        chk("err_a", 32'(err_a), 32'(ea.err));
        chk("done_time_a", cyc, ea.done_cyc);
      end
    end
    if (done_b) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL done_b: unexpected done at cycle %0d", cyc);
      end else begin
        eb = q_b.pop_front();
        chk("result_b", 32'(result_b), 32'(eb.res));
        chk("flags_b", 32'(flags_b), 32'(eb.flg));
        chk("err_b", 32'(err_b), 32'(eb.err));
        chk("done_time_b", cyc, eb.done_cyc);
      end
    end
  end

  task automatic scramble();
    op_a  = 4'($urandom); rs1_a = 3'($urandom); rs2_a = 3'($urandom);
    rd_a  = 3'($urandom); imm_a = 8'($urandom);
    op_b  = 4'($urandom); rs1_b = 4'($urandom); rs2_b = 4'($urandom);
    rd_b  = 4'($urandom); imm_b = 16'($urandom);
  endtask

  task automatic do_op(input bit sel, input logic [3:0] op, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [3:0] d, input logic [15:0] imm,
                       input logic [15:0] res, input logic [3:0] flg, input bit e);
    exp_t x;
    @(negedge clock);
    x.res = res; x.flg = flg; x.err = e; x.done_cyc = cyc + 4;
    if (!sel) begin
      start_a = 1'b1; op_a = op; rs1_a = s1[2:0]; rs2_a = s2[2:0]; rd_a = d[2:0]; imm_a = imm[7:0];
      q_a.push_back(x);
    end else begin
      start_b = 1'b1; op_b = op; rs1_b = s1; rs2_b = s2; rd_b = d; imm_b = imm;
      q_b.push_back(x);
    end
    @(posedge clock); #1;
    chk(sel ? "busy_b" : "busy_a", sel ? 32'(busy_b) : 32'(busy_a), 1);
    start_a = 1'b0;
    start_b = 1'b0;
    scramble();
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic chk_reg(input bit sel, input logic [3:0] a, input logic [15:0] exp, input string name);
    if (!sel) dbg_addr_a = a[2:0];
    else      dbg_addr_b = a;
    #1;
    chk(name, sel ? 32'(dbg_data_b) : 32'(dbg_data_a), 32'(exp));
  endtask

  initial begin
    exp_t x;
    reset_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    op_a = '0; rs1_a = '0; rs2_a = '0; rd_a = '0; imm_a = '0; dbg_addr_a = '0;
    op_b = '0; rs1_b = '0; rs2_b = '0; rd_b = '0; imm_b = '0; dbg_addr_b = '0;
    #1;
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_err", 32'(err_a), 0);
    chk("rst_result", 32'(result_a), 0);
    chk("rst_flags", 32'(flags_a), 0);
    chk("rst_r0", 32'(dbg_data_a), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // LDI/LDI/ADD with carry out
    do_op(0, 1, 0, 0, 1, 16'hF0, 16'hF0, 4'h0, 0);
    do_op(0, 1, 0, 0, 2, 16'h20, 16'h20, 4'h0, 0);
    do_op(0, 2, 1, 2, 3, 16'h00, 16'h10, 4'h8, 0);
    chk_reg(0, 3, 16'h10, "r3_add");

    // SUB self, then ADC with CV preset
    do_op(0, 1, 0, 0, 1, 16'h5A, 16'h5A, 4'h8, 0);
    do_op(0, 3, 1, 1, 5, 16'h00, 16'h00, 4'h1, 0);
    chk_reg(0, 5, 16'h00, "r5_sub");
    do_op(0, 1, 0, 0, 6, 16'hFF, 16'hFF, 4'h0, 0);
    do_op(0, 2, 6, 6, 7, 16'h00, 16'hFE, 4'h8, 0);
    do_op(0, 12, 6, 0, 3, 16'h00, 16'h00, 4'h9, 0);
    chk_reg(0, 3, 16'h00, "r3_adc");

    // CMP: B-A, GT, no write
    do_op(0, 1, 0, 0, 1, 16'h05, 16'h05, 4'h8, 0);
    do_op(0, 1, 0, 0, 2, 16'h03, 16'h03, 4'h8, 0);
    do_op(0, 9, 1, 2, 4, 16'h00, 16'hFE, 4'hA, 0);
    chk_reg(0, 4, 16'h00, "r4_cmp");

    // shifts and sticky SO
    do_op(0, 1, 0, 0, 1, 16'h81, 16'h81, 4'hA, 0);
    do_op(0, 7, 1, 0, 2, 16'h00, 16'h02, 4'hE, 0);
    do_op(0, 1, 0, 0, 1, 16'h01, 16'h01, 4'hE, 0);
    do_op(0, 8, 1, 0, 3, 16'h00, 16'h00, 4'hF, 0);
    do_op(0, 4, 1, 2, 4, 16'h00, 16'h00, 4'hF, 0);
    chk_reg(0, 2, 16'h02, "r2_shl");

    // illegal opcode: err with done, nothing changes
    do_op(0, 14, 1, 2, 1, 16'h55, 16'h00, 4'hF, 1);
    chk_reg(0, 1, 16'h01, "r1_illegal");

    // start held high: second op taken only in the done cycle
    @(negedge clock);
    start_a = 1'b1; op_a = 4'd1; rd_a = 3'd5; imm_a = 8'h33;
    x.res = 16'h33; x.flg = 4'hE; x.err = 1'b0; x.done_cyc = cyc + 4;
    q_a.push_back(x);
    @(posedge clock); #1;
    rd_a = 3'd6; imm_a = 8'h44;
    repeat (3) @(posedge clock);
    #1;
    x.res = 16'h44; x.done_cyc = cyc + 4;
    q_a.push_back(x);
    @(posedge clock); #1;
    start_a = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk_reg(0, 5, 16'h33, "r5_held");
    chk_reg(0, 6, 16'h44, "r6_held");

    // reset during EXEC aborts the ADD
    do_op(0, 1, 0, 0, 1, 16'h11, 16'h11, 4'hE, 0);
    do_op(0, 1, 0, 0, 2, 16'h22, 16'h22, 4'hE, 0);
    @(negedge clock);
    start_a = 1'b1; op_a = 4'd2; rs1_a = 3'd1; rs2_a = 3'd2; rd_a = 3'd5; dbg_addr_a = 3'd5;
    @(posedge clock); #1;
    start_a = 1'b0;
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_a), 0);
    chk("abort_done", 32'(done_a), 0);
    chk("abort_err", 32'(err_a), 0);
    chk("abort_result", 32'(result_a), 0);
    chk("abort_flags", 32'(flags_a), 0);
    chk("abort_r5", 32'(dbg_data_a), 0);
    @(negedge clock);
    reset_n = 1'b1;
    do_op(0, 1, 0, 0, 1, 16'h77, 16'h77, 4'h0, 0);
    chk_reg(0, 1, 16'h77, "r1_after_reset");

    // wide instance: 16-bit wrap and r15
    do_op(1, 1, 0, 0, 15, 16'hFFFF, 16'hFFFF, 4'h0, 0);
    do_op(1, 1, 0, 0, 14, 16'h0001, 16'h0001, 4'h0, 0);
    do_op(1, 2, 15, 14, 13, 16'h0000, 16'h0000, 4'h9, 0);
    chk_reg(1, 15, 16'hFFFF, "r15_wide");
    chk_reg(1, 13, 16'h0000, "r13_wide");

    repeat (3) @(negedge clock);
    chk("pending_a", q_a.size(), 0);
    chk("pending_b", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_exec_unit.md
PARAM_EXEC_UNIT -- requirements
Module: param_exec_unit

Interface
REQ-001 Parameter DATA_W, default 8: register, operand and result width in bits; legal values are 4 to 32.
REQ-002 Parameter ADDR_W, default 3: register address width; the register file SHALL hold NREGS = 2**ADDR_W registers.
REQ-003 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 start  in  1  request to begin an operation; sampled only in IDLE.
REQ-006 op  in  4  operation code, captured on the accepting edge.
REQ-007 rs1, rs2, rd  in  ADDR_W each  source and destination register addresses, captured on the accepting edge.
REQ-008 imm  in  DATA_W  immediate operand, captured on the accepting edge.
REQ-009 busy  out  1  high whenever state is not IDLE.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 err  out  1  one-cycle illegal-opcode pulse, coincident with done.
REQ-012 result  out  DATA_W  last computed result; registered.
REQ-013 flags  out  4  bit0 Z (zero), bit1 GT (compare greater), bit2 SO (shifted-out bit), bit3 CV (carry/borrow); registered.
REQ-014 dbg_addr  in  ADDR_W  debug read address.
REQ-015 dbg_data  out  DATA_W  combinational read of register[dbg_addr].

Function
REQ-016 The FSM states SHALL be IDLE, FETCH, EXEC and WB.
REQ-017 Transitions: IDLE->FETCH when start=1; FETCH->EXEC, EXEC->WB and WB->IDLE unconditionally.
REQ-018 start SHALL be ignored while busy=1.
REQ-019 Accepting edge k (IDLE, start=1): op, rs1, rs2, rd and imm SHALL be latched; the inputs may change afterwards without effect.
REQ-020 FETCH: A<=reg[rs1] and B<=reg[rs2].
REQ-021 EXEC: the result and next-flag values SHALL be computed from A, B, imm and the current CV, and registered.
REQ-022 WB: reg[rd], result and flags SHALL be written at edge k+3, and done=1 during the cycle following edge k+3.
REQ-023 A start asserted in the done cycle SHALL be accepted, giving back-to-back operations every 4 cycles.
REQ-024 Opcodes (all arithmetic modulo 2**DATA_W):
- 0 MOV: rd<=A.
- 1 LDI: rd<=imm.
- 2 ADD: rd<=A+B.
- 3 SUB: rd<=A-B.
- 4 AND.
- 5 OR.
- 6 XOR.
- 7 SHL: rd<=A<<1.
- 8 SHR: rd<=A>>1, logical.
- 9 CMP: computes B-A; no register write.
- 10 INC: rd<=A+1.
- 11 DEC: rd<=A-1.
- 12 ADC: rd<=A+B+CV.
REQ-025 Z SHALL equal (DATA_W-bit result==0) for every legal op, including CMP.
REQ-026 CV SHALL be the carry out of bit DATA_W-1 for ADD, ADC and INC, and the borrow for SUB and DEC; CV is unchanged for other ops.
REQ-027 GT SHALL be set to (A>B, unsigned) by CMP; GT is unchanged for other ops.
REQ-028 SO SHALL be set to A[DATA_W-1] for SHL and to A[0] for SHR; SO is unchanged for other ops.
REQ-029 For CMP, result SHALL update to B-A and no register SHALL be written.
REQ-030 Opcodes 13-15: no register, result or flag change; err=1 together with done.
REQ-031 rd equal to rs1 or rs2 is legal; the operands used are the values latched in FETCH.
REQ-032 dbg_data SHALL reflect a WB write from the cycle after edge k+3.

Reset
REQ-033 While reset_n=0, immediately and independent of clock: state IDLE, all registers 0, A=B=0, result=0, flags=0, busy=0, done=0, err=0.
REQ-034 Reset asserted mid-operation SHALL abort the operation with no writeback; after release the block SHALL accept start on the first rising edge.

Verification
REQ-035 Reset; LDI r1=0xF0; LDI r2=0x20; ADD rd=r3 -> result=0x10, CV=1, Z=0, dbg r3=0x10, done exactly 3 edges after the accepting edge.
REQ-036 SUB r1-r1 with r1=0x5A -> result 0x00, Z=1, CV=0; then ADC 0xFF+0x00 with CV preset to 1 -> 0x00, Z=1, CV=1.
REQ-037 r1=5, r2=3, CMP rs1=r1, rs2=r2, rd=r4 -> GT=1, result=0xFE, r4 unchanged (0).
REQ-038 SHL r=0x81 -> 0x02, SO=1; SHR r=0x01 -> 0x00, Z=1, SO=1; AND afterwards leaves SO=1.
REQ-039 start held high through an operation -> a second op is accepted only in the done cycle; op=14 -> err=1 with done, with flags and registers unchanged.
REQ-040 reset_n pulsed low during EXEC of ADD -> rd not written and all outputs 0.
REQ-041 With DATA_W=16 and ADDR_W=4: 0xFFFF+0x0001 -> 0x0000, Z=1, CV=1, and r15 is reachable.
